// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache geometry, address field ranges and fill-controller state encoding.
// The data array, tag array and cache top all import these definitions.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int NUM_SETS        = 64;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;

  localparam int OFFSET_LSB = 1;
  localparam int OFFSET_MSB = 3;
  localparam int INDEX_LSB  = 4;
  localparam int INDEX_MSB  = 9;
  localparam int TAG_LSB    = 10;
  localparam int TAG_MSB    = 15;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_e;

  // First byte of the block that contains addr.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    block_base = {addr[TAG_MSB:TAG_LSB], addr[INDEX_MSB:INDEX_LSB], {(OFFSET_MSB+1){1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_onehot_decoder.sv
// N-to-2^N one-hot decoder with enable; all zeros when disabled.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic              en,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] onehot
);

  always_comb begin
    // NOTE: default first so every path assigns onehot and no latch is inferred.
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss fill controller: issues one word read per cycle for the missing block and
// writes returning words straight into the data array, tag on the final beat.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
  parameter int NUM_SETS        = cache_fill_fsm_pkg::NUM_SETS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [ADDR_W-1:0]          miss_address,
  input  logic                       memory_data_valid,
  input  logic [DATA_W-1:0]          memory_data_in,
  output logic                       fsm_busy,
  output logic                       mem_ren,
  output logic [ADDR_W-1:0]          memory_address,
  output logic                       write_data_array,
  output logic [DATA_W-1:0]          data_out,
  output logic [NUM_SETS-1:0]        set_enable,
  output logic [WORDS_PER_BLOCK-1:0] word_enable,
  output logic                       write_tag_array
);

  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam logic [WORD_W:0]   ISSUE_DONE = (WORD_W+1)'(WORDS_PER_BLOCK);
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS_PER_BLOCK - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_W:0]   icnt_q, icnt_d;   // one extra bit so it can rest at WORDS_PER_BLOCK
  logic [WORD_W-1:0] rcnt_q, rcnt_d;

  assign fsm_busy = (state_q == FILL_BUSY);

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    icnt_d           = icnt_q;
    rcnt_d           = rcnt_q;
    mem_ren          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_out         = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      FILL_IDLE: begin
        if (miss_detected) begin
          state_d = FILL_BUSY;
          base_d  = block_base(miss_address);
          icnt_d  = '0;
          rcnt_d  = '0;
        end
      end
      FILL_BUSY: begin
        if (icnt_q < ISSUE_DONE) begin
          mem_ren        = 1'b1;
          memory_address = base_q + (ADDR_W'(icnt_q) << OFFSET_LSB);
          icnt_d         = icnt_q + 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_out         = memory_data_in;
          if (rcnt_q == LAST_WORD) begin
            write_tag_array = 1'b1;
            state_d         = FILL_IDLE;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL_IDLE;
      base_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q <= state_d;
      base_q  <= base_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  onehot_decoder #(.N(INDEX_W)) u_set_dec (
    .en     (fsm_busy),
    .sel    (base_q[INDEX_LSB +: INDEX_W]),
    .onehot (set_enable)
  );

  onehot_decoder #(.N(WORD_W)) u_word_dec (
    .en     (write_data_array),
    .sel    (rcnt_q),
    .onehot (word_enable)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised bench: the driver pushes expected requests and array writes into queues,
// an independent negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        fsm_busy;
  logic        mem_ren;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] data_out;
  logic [63:0] set_enable;
  logic [7:0]  word_enable;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .mem_ren           (mem_ren),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_out          (data_out),
    .set_enable        (set_enable),
    .word_enable       (word_enable),
    .write_tag_array   (write_tag_array)
  );

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } req_t;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  we;
    logic [63:0] se;
    logic        tag;
    int          cyc;
  } wr_t;

  req_t req_q[$];
  wr_t  wr_q[$];
  logic exp_busy;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: independent of the driver, only consumes the queues.
  always @(negedge clk) begin
    req_t r;
    wr_t  w;
    check("busy", {63'd0, fsm_busy}, {63'd0, exp_busy});
    if (!exp_busy) check("idle_set_enable", set_enable, 64'd0);
    if (mem_ren) begin
      if (req_q.size() == 0) unexpected("extra_request", {48'd0, memory_address});
      else begin
        r = req_q.pop_front();
        check("req_addr", {48'd0, memory_address}, {48'd0, r.addr});
        check("req_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (write_data_array) begin
      if (wr_q.size() == 0) unexpected("extra_write", {48'd0, data_out});
      else begin
        w = wr_q.pop_front();
        check("wr_data", {48'd0, data_out}, {48'd0, w.data});
        check("wr_word_enable", {56'd0, word_enable}, {56'd0, w.we});
        check("wr_set_enable", set_enable, w.se);
        check("wr_tag", {63'd0, write_tag_array}, {63'd0, w.tag});
        check("wr_cycle", 64'(cyc), 64'(w.cyc));
      end
    end else begin
      check("idle_word_enable", {56'd0, word_enable}, 56'd0);
      check("stray_tag", {63'd0, write_tag_array}, 64'd0);
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {60'd0, fsm_busy, mem_ren, write_data_array, write_tag_array}, 64'd0);
    check({name, "_addr_data"}, {32'd0, memory_address, data_out}, 64'd0);
    check({name, "_set"}, set_enable, 64'd0);
    check({name, "_word"}, {56'd0, word_enable}, 64'd0);
  endtask

  // mode 0: fixed latency 4, data 0x1000+k; mode 1: random gaps; mode 2: gaps plus a stray miss.
  // abort_after >= 0 asserts reset once that many beats have been returned.
  task automatic do_fill(input logic [15:0] addr, input int mode, input int abort_after);
    int          start;
    int          beat_cyc[8];
    int          last;
    int          k;
    logic [15:0] base;
    logic [5:0]  idx;
    logic [63:0] se;
    start = cyc;
    base  = addr & 16'hFFF0;
    idx   = 6'((addr >> 4) & 16'h3F);
    se    = 64'd1 << idx;
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'b0;
    for (int i = 0; i < 8; i++) req_q.push_back('{base + 16'(2 * i), start + 1 + i});
    for (int i = 0; i < 8; i++) begin
      if (mode == 0)   beat_cyc[i] = start + 5 + i;
      else if (i == 0) beat_cyc[i] = start + 2 + int'($urandom_range(0, 3));
      else             beat_cyc[i] = beat_cyc[i-1] + 1 + int'($urandom_range(0, 3));
    end
    last = beat_cyc[7];
    k = 0;
    for (int c = start + 1; c <= last + 1; c++) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      memory_data_in    = 16'($urandom);
      if (mode == 2 && c == start + 3) begin
        miss_detected = 1'b1;
        miss_address  = 16'($urandom);
      end
      if (c == start + 1) exp_busy = 1'b1;
      if (k < 8 && c == beat_cyc[k]) begin
        if (k == abort_after) begin
          #1;
          rst      = 1'b0;
          exp_busy = 1'b0;
          req_q.delete();
          wr_q.delete();
          #1;
          check_all_zero("async_reset");
          repeat (2) @(posedge clk);
          #1;
          rst = 1'b1;
          return;
        end
        memory_data_valid = 1'b1;
        if (mode == 0) memory_data_in = 16'h1000 + 16'(k);
        wr_q.push_back('{memory_data_in, 8'd1 << k, se, (k == 7), c});
        k++;
      end
      if (c == last + 1) exp_busy = 1'b0;
    end
    check("requests_left", 64'(req_q.size()), 64'd0);
    check("writes_left", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic idle_spurious(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'($urandom);
      memory_data_in    = 16'($urandom);
    end
    @(posedge clk);
    #1;
    memory_data_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    n_cmp             = 0;
    n_fail            = 0;
    exp_busy          = 1'b0;
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data_in    = '0;
    #1 rst = 1'b0;

    repeat (4) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'($urandom);
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom);
      memory_data_in    = 16'($urandom);
      #1 check_all_zero("in_reset");
    end
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_fill(16'h1A36, 0, -1);
    idle_spurious(4);
    for (int i = 0; i < 4; i++) do_fill(16'($urandom), 1, -1);
    do_fill(16'($urandom), 2, -1);
    idle_spurious(3);
    do_fill(16'($urandom), 1, 3);
    do_fill(16'hFFF0, 0, -1);
    do_fill(16'($urandom), 0, -1);
    do_fill(16'($urandom), 1, -1);
    do_fill(16'($urandom), 0, -1);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits directly upstream of the per-way data array and tag array. On a cache miss it fetches the 16-byte block containing the missing address from main memory, one 16-bit word per beat. Each returned word is written into the data array using one-hot set and word enables. The tag array is written on the final beat. The L1 hit path stalls on `fsm_busy` until the fill completes.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 8: words per cache block; sets word counter width of 3 bits.
- `NUM_SETS`, 64: sets per way; sets index width of 6 bits.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `miss_detected` in 1: cache miss this cycle; sampled only in IDLE.
- `miss_address` in 16: byte address of the miss; sampled with `miss_detected`.
- `memory_data_valid` in 1: main memory returns one word this cycle.
- `memory_data_in` in 16: returned word.
- `fsm_busy` out 1: fill in progress; the stall request to the pipeline.
- `mem_ren` out 1: read request to main memory this cycle.
- `memory_address` out 16: word address issued with `mem_ren`.
- `write_data_array` out 1: write strobe to the data array (its `wen`).
- `data_out` out 16: word to write; drives the data array `data_in`.
- `set_enable` out 64: one-hot set select.
- `word_enable` out 8: one-hot word select.
- `write_tag_array` out 1: one-cycle tag write strobe.

## Operation
- Address split: offset `[3:1]` selects the word, `[9:4]` is the set index, `[15:10]` is the tag. Bit 0 is ignored.
- States:
  - IDLE -> FILL when `miss_detected`=1. On that edge:
    - latch block base = `miss_address & 16'hFFF0`;
    - clear the issue counter `icnt` and the return counter `rcnt`.
  - FILL -> IDLE on the edge where `memory_data_valid`=1 and `rcnt`=7.
- Request issue in FILL:
  - `mem_ren`=1 while `icnt`<8.
  - `memory_address` = base + 2*`icnt`; `icnt` increments each cycle.
  - Exactly 8 requests per fill: 0x…0, 0x…2, … 0x…E.
- Data return in FILL (driven combinationally, same cycle as `memory_data_valid`):
  - `write_data_array`=1;
  - `data_out`=`memory_data_in`;
  - `word_enable`=1<<`rcnt`;
  - `rcnt` increments on each such cycle.
- `set_enable`=1<<latched index throughout FILL; all zeros in IDLE.
- `write_tag_array`=1 only in the cycle of the 8th valid beat.
- `fsm_busy`=1 in FILL.
- Boundary cases:
  - `miss_detected` during FILL is ignored; the pipeline re-asserts it after the stall.
  - `memory_data_valid` in IDLE is ignored: no write, no counter change.
  - A valid beat in the same cycle as a request is legal; the two counters are independent.
  - `rcnt` never exceeds 7; `icnt` saturates at 8.
  - Reset mid-fill forces IDLE and zeroes the counters. Partially written words stay in the array with the tag unwritten, so the line remains invalid.

## Timing
- Reset values: state IDLE, `icnt`=`rcnt`=0, latched base 0. All outputs 0, including `set_enable` and `word_enable`.
- Fill latency:
  - Cycle 0: `miss_detected` sampled.
  - Cycle 1: `fsm_busy` rises and the first `mem_ren` issues.
  - Cycles 1-8: requests.
  - With fixed memory latency L (4 in the system), beat k arrives in cycle 1+k+L. The last beat arrives in cycle 12.
  - `fsm_busy` falls in cycle 13.
- Back-to-back: a new `miss_detected` in the first IDLE cycle starts the next fill one cycle later.
- Data path from `memory_data_in` to `data_out` is combinational, with no added register.

## Structure
- Shared include/package holds:
  - `WORDS_PER_BLOCK`, `NUM_SETS`;
  - offset/index/tag bit-range constants;
  - state encodings `FILL_IDLE`/`FILL_BUSY`.
  The data array, tag array and cache top use the same constants.
- One sub-module: `onehot_decoder`, parameterised N-to-2^N, instantiated twice (6->64 for sets, 3->8 for words). The tag/metadata path reuses it.

## Test plan
- Reset: hold `rst`=0 with random inputs -> every output is 0 and `fsm_busy`=0; release -> stays IDLE.
- Basic fill: `miss_address`=16'h1A36, memory latency 4 returning 0x1000..0x1007 ->
  - requests at 0x1A30..0x1A3E in cycles 1-8;
  - set_enable bit 35 set;
  - word_enable 0x01..0x80 with the matching data;
  - `write_tag_array` pulses only in cycle 12;
  - `fsm_busy` low in cycle 13.
- Irregular memory: valid beats with random gaps of 0-3 cycles -> exactly 8 writes in order and 8 requests; tag write on the 8th beat only.
- Spurious inputs: `miss_detected` pulsed mid-fill and `memory_data_valid` pulsed in IDLE -> no new fill, no array write, counters unchanged.
- Reset mid-fill: assert `rst` after 3 returned beats -> all outputs 0 immediately (async). After release a fresh miss at 16'hFFF0 -> full 8-beat fill of set 63.
- Back-to-back misses: second miss in the first IDLE cycle after a fill -> new fill starts next cycle with the new base; no stale counts.
